// File: rtl/tdc_uart_tx.sv
// Serial result transmitter: snapshots the TDC thermometer word and sends it as
// a burst of UART 8N1 frames (header byte, then payload bytes, LSB byte first).
module tdc_uart_tx #(
    parameter int         num_stages   = 10,
    parameter int         clks_per_bit = 868,
    parameter logic [7:0] header_byte  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [num_stages-1:0] stage_delays,
    input  logic                  send,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int NBYTES = (num_stages + 7) / 8;
    localparam int PW     = 8 * NBYTES;
    localparam int TW     = $clog2(clks_per_bit);
    localparam int BYW    = $clog2(NBYTES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(clks_per_bit - 1);
    localparam logic [BYW-1:0] BYTE_LAST  = BYW'(NBYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [BYW-1:0] byte_idx_r, byte_idx_s;
    logic [7:0]     shift_r, shift_s;
    logic [PW-1:0]  payload_r, payload_s;
    logic           finish_s;
    logic           timer_end_s;
    logic           tx_s, busy_s, done_s;
    logic           tx_r, busy_r, done_r;

    // State, datapath and output registers; outputs are loaded from the
    // next-state values so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            timer_r    <= '0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= '0;
            shift_r    <= 8'd0;
            payload_r  <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            payload_r  <= payload_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Next-state and datapath sequencing through header and payload frames.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        bit_idx_s   = bit_idx_r;
        byte_idx_s  = byte_idx_r;
        shift_s     = shift_r;
        payload_s   = payload_r;
        finish_s    = 1'b0;
        timer_end_s = (timer_r == TIMER_LAST);
        case (state_r)
            IDLE: begin
                if (send) begin
                    state_s    = START;
                    timer_s    = '0;
                    bit_idx_s  = 3'd0;
                    byte_idx_s = '0;
                    shift_s    = header_byte;
                    payload_s  = PW'(stage_delays);
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (timer_end_s) begin
                    timer_s   = '0;
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    timer_s = timer_r + TW'(1'b1);
                end
            end
            DATA: begin
                if (timer_end_s) begin
                    timer_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    timer_s = timer_r + TW'(1'b1);
                end
            end
            STOP: begin
                if (timer_end_s) begin
                    timer_s = '0;
                    if (byte_idx_r == BYTE_LAST) begin
                        state_s  = IDLE;
                        finish_s = 1'b1;
                    end else begin
                        // Payload is consumed low byte first by shifting right.
                        shift_s    = payload_r[7:0];
                        payload_s  = payload_r >> 4'd8;
                        byte_idx_s = byte_idx_r + BYW'(1'b1);
                        state_s    = START;
                    end
                end else begin
                    timer_s = timer_r + TW'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, registered above.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = (state_s != IDLE);
        done_s = finish_s;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
